led_show_sequencer: RTL and testbench

- Controller that replays the stored jogada sequence on the 4 LEDs during the "show" phase of each round.
- Reads RAM entries 0..last_addr in order, holds each pattern on the LEDs for T_ON ticks, then blanks them for T_OFF ticks, and pulses pronto when the sequence is finished.
- Sits between UC_projeto, which issues iniciar and receives pronto, and the FD RAM, which provides the address and read data; it replaces the ad-hoc ledToshow timing.
- Clocked by the paused 1 kHz game clock, so it freezes together with the rest of the game.

---
 rtl/led_show_if.sv | 38 +++
 rtl/led_show_sequencer.sv | 144 ++++++++++++++
 tb/tb_led_show_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_show_if.sv
// Bus between UC_projeto / FD RAM and led_show_sequencer: start/done handshake, RAM read port, LEDs, debug.
// With LED_SHOW_ABORT_EN defined, the abortar/abortado pair is added.
interface led_show_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
);
  logic              iniciar;
  logic              pausa;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;
`ifdef LED_SHOW_ABORT_EN
  logic              abortar;
  logic              abortado;

  modport master (
    output iniciar, pausa, last_addr, mem_data, abortar,
    input  mem_addr, leds, ocupado, pronto, db_estado, abortado
  );
  modport slave (
    input  iniciar, pausa, last_addr, mem_data, abortar,
    output mem_addr, leds, ocupado, pronto, db_estado, abortado
  );
`else
  modport master (
    output iniciar, pausa, last_addr, mem_data,
    input  mem_addr, leds, ocupado, pronto, db_estado
  );
  modport slave (
    input  iniciar, pausa, last_addr, mem_data,
    output mem_addr, leds, ocupado, pronto, db_estado
  );
`endif
endinterface

// File: rtl/led_show_sequencer.sv
// Replays RAM entries 0..last_addr on the LEDs: T_ON ticks lit, T_OFF ticks dark, then pulses pronto.
// Optional abort (abortar/abortado) is enabled by defining LED_SHOW_ABORT_EN.
module led_show_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned T_ON   = 500,
  parameter int unsigned T_OFF  = 250
) (
  input logic        clock,
  input logic        reset,
  led_show_if.slave  bus
);

  localparam int unsigned T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned TMR_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ON    = 3'd3,
    S_OFF   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              ocupado_q, ocupado_d;
  logic              pronto_q, pronto_d;
  state_t            entry_state;
  logic [ADDR_W-1:0] entry_addr;
`ifdef LED_SHOW_ABORT_EN
  logic              abortado_q, abortado_d;
`endif

  // Every register freezes while pausa is high; reset overrides pausa.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      leds_q     <= '0;
      timer_q    <= '0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
`ifdef LED_SHOW_ABORT_EN
      abortado_q <= 1'b0;
`endif
    end else if (!bus.pausa) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      leds_q     <= leds_d;
      timer_q    <= timer_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
`ifdef LED_SHOW_ABORT_EN
      abortado_q <= abortado_d;
`endif
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    leds_d      = leds_q;
    timer_d     = timer_q;
    entry_state = S_FETCH;
    entry_addr  = addr_q + ADDR_W'(1);
`ifdef LED_SHOW_ABORT_EN
    abortado_d  = 1'b0;
`endif

    // End-of-entry decision, shared by ON (no gap) and OFF.
    if (addr_q == bus.last_addr) begin
      entry_state = S_DONE;
      entry_addr  = addr_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.iniciar) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        leds_d  = bus.mem_data;
        timer_d = '0;
        state_d = S_ON;
      end
      S_ON: begin
        if (timer_q == TMR_W'(T_ON - 1)) begin
          leds_d  = '0;
          timer_d = '0;
          if (T_OFF > 0) begin
            state_d = S_OFF;
          end else begin
            state_d = entry_state;
            addr_d  = entry_addr;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_OFF: begin
        if (timer_q == TMR_W'(T_OFF - 1)) begin
          timer_d = '0;
          state_d = entry_state;
          addr_d  = entry_addr;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef LED_SHOW_ABORT_EN
    if (bus.abortar && (state_q inside {S_FETCH, S_LOAD, S_ON, S_OFF})) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      leds_d     = '0;
      timer_d    = '0;
      abortado_d = 1'b1;
    end
`endif

    ocupado_d = (state_d inside {S_FETCH, S_LOAD, S_ON, S_OFF});
    pronto_d  = (state_d == S_DONE);
  end

  assign bus.mem_addr  = addr_q;
  assign bus.leds      = leds_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.pronto    = pronto_q;
  assign bus.db_estado = 4'(state_q);
`ifdef LED_SHOW_ABORT_EN
  assign bus.abortado  = abortado_q;
`endif

endmodule

// File: tb/tb_led_show_sequencer.sv
// Bench for led_show_sequencer: table of shows checked against a per-step LED scoreboard,
// plus hand sequences for no-gap build, held iniciar, restart-ignore/reset and abort.
`timescale 1ns/1ps
module tb_led_show_sequencer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned T_ON   = 3;
  localparam int unsigned T_OFF  = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  led_show_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  led_show_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  led_show_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ON(T_ON), .T_OFF(T_OFF)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  led_show_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ON(T_ON), .T_OFF(0)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  // Synchronous RAM model shared by both instances.
  logic [DATA_W-1:0] ram [16];
  always @(posedge clock) begin
    bus_a.mem_data <= ram[bus_a.mem_addr];
    bus_b.mem_data <= ram[bus_b.mem_addr];
  end

  typedef struct {
    logic [3:0] last;
    int         pause_at;
    int         pause_len;
    int         exp_len;
  } vec_t;

  vec_t              vecs [5];
  logic [DATA_W-1:0] exp_q [$];
  int                errors = 0;
  int                checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one show on dut_a; leds are popped from the scoreboard on every unpaused ON/OFF cycle.
  task automatic run_show(input vec_t v);
    int                pronto_idx;
    logic              paused_prev;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] e;
    for (int n = 0; n <= int'(v.last); n++) begin
      for (int k = 0; k < int'(T_ON); k++) exp_q.push_back(ram[n]);
      for (int k = 0; k < int'(T_OFF); k++) exp_q.push_back('0);
    end
    pronto_idx      = -1;
    paused_prev     = 1'b0;
    held            = '0;
    bus_a.last_addr = v.last;
    bus_a.iniciar   = 1'b1;
    for (int idx = 0; idx < 200; idx++) begin
      @(negedge clock);
      if (idx == 0) bus_a.iniciar = 1'b0;
      if (paused_prev) begin
        check("pause_hold_leds", 32'(bus_a.leds), 32'(held));
      end else if (bus_a.db_estado == 4'd3 || bus_a.db_estado == 4'd4) begin
        if (exp_q.size() == 0) begin
          check("leds_extra_step", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("leds_step", 32'(bus_a.leds), 32'(e));
        end
      end
      held = bus_a.leds;
      if (bus_a.pronto) begin
        pronto_idx = idx;
        check("ocupado_with_pronto", 32'(bus_a.ocupado), 32'd0);
        break;
      end
      bus_a.pausa = (v.pause_len > 0) && (idx >= v.pause_at) && (idx < v.pause_at + v.pause_len);
      paused_prev = bus_a.pausa;
    end
    bus_a.pausa = 1'b0;
    check("pronto_cycle", 32'(pronto_idx), 32'(v.exp_len - 1 + v.pause_len));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);
    check("pronto_one_cycle", 32'(bus_a.pronto), 32'd0);
    check("back_to_idle", 32'(bus_a.db_estado), 32'd0);
  endtask

  initial begin
    int pronto_cnt;
    int pronto_idx;
    int off_seen;
    logic [DATA_W-1:0] e;

    // Full show is (last+1)*(2+T_ON+T_OFF)+1 cycles, FETCH to end of DONE.
    vecs[0] = '{4'd2, 0, 0, 22};
    vecs[1] = '{4'd0, 0, 0, 8};
    vecs[2] = '{4'd1, 0, 0, 15};
    vecs[3] = '{4'd2, 10, 7, 22};
    vecs[4] = '{4'd3, 0, 0, 29};

    for (int i = 0; i < 16; i++) ram[i] = 4'b1111;
    ram[0] = 4'b0001;
    ram[1] = 4'b0100;
    ram[2] = 4'b1000;
    ram[3] = 4'b0000;

    reset = 1'b1;
    bus_a.iniciar = 1'b0; bus_a.pausa = 1'b0; bus_a.last_addr = '0;
    bus_b.iniciar = 1'b0; bus_b.pausa = 1'b0; bus_b.last_addr = '0;
`ifdef LED_SHOW_ABORT_EN
    bus_a.abortar = 1'b0;
    bus_b.abortar = 1'b0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_leds", 32'(bus_a.leds), 32'd0);
    check("rst_ocupado", 32'(bus_a.ocupado), 32'd0);
    check("rst_pronto", 32'(bus_a.pronto), 32'd0);
    check("rst_db_estado", 32'(bus_a.db_estado), 32'd0);
    check("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    check("rst_b_db_estado", 32'(bus_b.db_estado), 32'd0);

    for (int i = 0; i < 5; i++) run_show(vecs[i]);

    // No-gap build, single entry: FETCH, LOAD, 3x ON, DONE; OFF never entered.
    for (int k = 0; k < int'(T_ON); k++) exp_q.push_back(ram[0]);
    off_seen = 0;
    pronto_idx = -1;
    bus_b.last_addr = 4'd0;
    bus_b.iniciar = 1'b1;
    for (int idx = 0; idx < 40; idx++) begin
      @(negedge clock);
      if (idx == 0) bus_b.iniciar = 1'b0;
      if (bus_b.db_estado == 4'd4) off_seen++;
      if (bus_b.db_estado == 4'd3) begin
        if (exp_q.size() == 0) check("b_leds_extra_step", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("b_leds_step", 32'(bus_b.leds), 32'(e));
        end
      end
      if (bus_b.pronto) begin
        pronto_idx = idx;
        break;
      end
    end
    check("b_pronto_cycle", 32'(pronto_idx), 32'd5);
    check("b_off_never", 32'(off_seen), 32'd0);
    check("b_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);

    // iniciar held high: ignored while busy, new show one cycle after DONE's IDLE.
    bus_a.last_addr = 4'd0;
    bus_a.iniciar = 1'b1;
    for (int idx = 0; idx < 10; idx++) begin
      @(negedge clock);
      if (idx == 3) check("held_in_on", 32'(bus_a.db_estado), 32'd3);
      if (idx == 7) check("held_pronto", 32'(bus_a.pronto), 32'd1);
      if (idx == 8) check("held_idle", 32'(bus_a.db_estado), 32'd0);
      if (idx == 9) check("held_restart", 32'(bus_a.db_estado), 32'd1);
    end
    bus_a.iniciar = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // iniciar during OFF is ignored; reset in the third ON aborts silently.
    pronto_cnt = 0;
    bus_a.last_addr = 4'd2;
    bus_a.iniciar = 1'b1;
    for (int idx = 0; idx <= 16; idx++) begin
      @(negedge clock);
      if (bus_a.pronto) pronto_cnt++;
      bus_a.iniciar = (idx == 5);
      if (idx == 5) check("off_state", 32'(bus_a.db_estado), 32'd4);
      if (idx == 7) begin
        check("no_restart_state", 32'(bus_a.db_estado), 32'd1);
        check("no_restart_addr", 32'(bus_a.mem_addr), 32'd1);
      end
      if (idx == 16) check("third_on_leds", 32'(bus_a.leds), 32'(4'b1000));
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_state", 32'(bus_a.db_estado), 32'd0);
    check("mid_rst_leds", 32'(bus_a.leds), 32'd0);
    check("mid_rst_ocupado", 32'(bus_a.ocupado), 32'd0);
    check("mid_rst_addr", 32'(bus_a.mem_addr), 32'd0);
    for (int idx = 0; idx < 30; idx++) begin
      @(negedge clock);
      if (bus_a.pronto) pronto_cnt++;
    end
    check("mid_rst_no_pronto", 32'(pronto_cnt), 32'd0);
    check("mid_rst_stays_idle", 32'(bus_a.db_estado), 32'd0);

`ifdef LED_SHOW_ABORT_EN
    // abortar in the second ON returns to IDLE with a one-cycle abortado and no pronto.
    pronto_cnt = 0;
    bus_a.last_addr = 4'd2;
    bus_a.iniciar = 1'b1;
    for (int idx = 0; idx <= 10; idx++) begin
      @(negedge clock);
      if (bus_a.pronto) pronto_cnt++;
      if (idx == 0) bus_a.iniciar = 1'b0;
      if (idx == 10) begin
        check("abort_pre_leds", 32'(bus_a.leds), 32'(4'b0100));
        bus_a.abortar = 1'b1;
      end
    end
    @(negedge clock);
    bus_a.abortar = 1'b0;
    check("abort_state", 32'(bus_a.db_estado), 32'd0);
    check("abort_leds", 32'(bus_a.leds), 32'd0);
    check("abort_flag", 32'(bus_a.abortado), 32'd1);
    check("abort_ocupado", 32'(bus_a.ocupado), 32'd0);
    check("abort_addr", 32'(bus_a.mem_addr), 32'd0);
    @(negedge clock);
    check("abort_flag_one_cycle", 32'(bus_a.abortado), 32'd0);
    for (int idx = 0; idx < 10; idx++) begin
      @(negedge clock);
      if (bus_a.pronto) pronto_cnt++;
    end
    check("abort_no_pronto", 32'(pronto_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
